// File: rtl/riscv_pkg.sv
// Shared RISC-V types used by the issue path.
// The instruction word is carried as its decoded R-type fields.
package riscv_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } riscv_instr_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch, issue and result-bus signals of the reservation station.
// master = surrounding pipeline, slave = the station itself.
interface reservation_station_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 5
);
  import riscv_pkg::*;

  logic                  dispatch_valid_i;
  logic                  dispatch_ready_o;
  riscv_instr_t          dispatch_opcode_i;
  logic                  dispatch_rs1_ready_i;
  logic [DATA_WIDTH-1:0] dispatch_rs1_value_i;
  logic [TAG_W-1:0]      dispatch_rs1_tag_i;
  logic                  dispatch_rs2_ready_i;
  logic [DATA_WIDTH-1:0] dispatch_rs2_value_i;
  logic [TAG_W-1:0]      dispatch_rs2_tag_i;
  logic [TAG_W-1:0]      dispatch_rob_tag_i;

  logic                  issue_valid_o;
  logic                  issue_ready_i;
  riscv_instr_t          issue_opcode_o;
  logic [DATA_WIDTH-1:0] issue_v_rs1_o;
  logic [DATA_WIDTH-1:0] issue_v_rs2_o;
  logic [TAG_W-1:0]      issue_rob_tag_o;

  logic                  cdb_valid_i;
  logic [TAG_W-1:0]      cdb_rob_tag_i;
  logic [DATA_WIDTH-1:0] cdb_data_i;

  modport master (
    output dispatch_valid_i,
    input  dispatch_ready_o,
    output dispatch_opcode_i,
    output dispatch_rs1_ready_i,
    output dispatch_rs1_value_i,
    output dispatch_rs1_tag_i,
    output dispatch_rs2_ready_i,
    output dispatch_rs2_value_i,
    output dispatch_rs2_tag_i,
    output dispatch_rob_tag_i,
    input  issue_valid_o,
    output issue_ready_i,
    input  issue_opcode_o,
    input  issue_v_rs1_o,
    input  issue_v_rs2_o,
    input  issue_rob_tag_o,
    output cdb_valid_i,
    output cdb_rob_tag_i,
    output cdb_data_i
  );

  modport slave (
    input  dispatch_valid_i,
    output dispatch_ready_o,
    input  dispatch_opcode_i,
    input  dispatch_rs1_ready_i,
    input  dispatch_rs1_value_i,
    input  dispatch_rs1_tag_i,
    input  dispatch_rs2_ready_i,
    input  dispatch_rs2_value_i,
    input  dispatch_rs2_tag_i,
    input  dispatch_rob_tag_i,
    output issue_valid_o,
    input  issue_ready_i,
    output issue_opcode_o,
    output issue_v_rs1_o,
    output issue_v_rs2_o,
    output issue_rob_tag_o,
    input  cdb_valid_i,
    input  cdb_rob_tag_i,
    input  cdb_data_i
  );

endinterface

// File: rtl/reservation_station.sv
// Unified reservation station: buffers dispatched ops, snoops the CDB
// for operands and issues the lowest-index ready entry each cycle.
module reservation_station
  import riscv_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int ROB_SIZE    = 32,
  parameter  int NUM_ENTRIES = 8,
  localparam int TAG_W       = $clog2(ROB_SIZE),
  localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  reservation_station_if.slave     bus,
  output logic [CNT_W-1:0]         occupancy_o
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_ENTRIES);

  typedef struct packed {
    logic                  rdy;
    logic [TAG_W-1:0]      tag;
    logic [DATA_WIDTH-1:0] val;
  } opnd_t;

  logic [NUM_ENTRIES-1:0] r_valid;
  riscv_instr_t           r_op  [NUM_ENTRIES];
  logic [TAG_W-1:0]       r_rob [NUM_ENTRIES];
  opnd_t                  r_s1  [NUM_ENTRIES];
  opnd_t                  r_s2  [NUM_ENTRIES];
  logic [CNT_W-1:0]       r_occ;

  logic [NUM_ENTRIES-1:0] w_rdy;
  logic [IDX_W-1:0]       w_sel;
  logic [IDX_W-1:0]       w_free;
  logic                   w_any;
  logic                   w_has_free;
  logic                   w_dready;
  logic                   w_iv;
  logic                   w_disp;
  logic                   w_iss;
  opnd_t                  w_d1;
  opnd_t                  w_d2;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_rdy[i] = r_valid[i] & r_s1[i].rdy & r_s2[i].rdy;
    end
  end

  // Fixed priority: scan downwards so the lowest index wins.
  always_comb begin
    w_sel      = '0;
    w_any      = 1'b0;
    w_free     = '0;
    w_has_free = 1'b0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_sel = IDX_W'(i);
        w_any = 1'b1;
      end
      if (!r_valid[i]) begin
        w_free     = IDX_W'(i);
        w_has_free = 1'b1;
      end
    end
  end

  assign w_dready = (r_occ < FULL);
  assign w_iv     = w_any & ~flush_i;
  assign w_disp   = bus.dispatch_valid_i & w_dready & ~flush_i;
  assign w_iss    = w_iv & bus.issue_ready_i;

  // A producer broadcasting in the dispatch cycle is captured directly.
  always_comb begin
    w_d1.tag = bus.dispatch_rs1_tag_i;
    w_d1.rdy = bus.dispatch_rs1_ready_i |
               (bus.cdb_valid_i &
                (bus.cdb_rob_tag_i == bus.dispatch_rs1_tag_i));
    w_d1.val = bus.dispatch_rs1_ready_i ?
               bus.dispatch_rs1_value_i : bus.cdb_data_i;
    w_d2.tag = bus.dispatch_rs2_tag_i;
    w_d2.rdy = bus.dispatch_rs2_ready_i |
               (bus.cdb_valid_i &
                (bus.cdb_rob_tag_i == bus.dispatch_rs2_tag_i));
    w_d2.val = bus.dispatch_rs2_ready_i ?
               bus.dispatch_rs2_value_i : bus.cdb_data_i;
  end

  assign bus.dispatch_ready_o = w_dready;
  assign bus.issue_valid_o    = w_iv;
  assign bus.issue_opcode_o   = w_iv ? r_op[w_sel]     : '0;
  assign bus.issue_v_rs1_o    = w_iv ? r_s1[w_sel].val : '0;
  assign bus.issue_v_rs2_o    = w_iv ? r_s2[w_sel].val : '0;
  assign bus.issue_rob_tag_o  = w_iv ? r_rob[w_sel]    : '0;
  assign occupancy_o          = r_occ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else begin
      if (w_iss) r_valid[w_sel] <= 1'b0;
      if (w_disp) r_valid[w_free] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_occ <= '0;
    end else if (flush_i) begin
      r_occ <= '0;
    end else begin
      case ({w_disp, w_iss})
        2'b10: if (r_occ != FULL) r_occ <= r_occ + 1'b1;
        2'b01: if (r_occ != '0) r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Payload carries no reset; validity alone qualifies it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_valid[i] && bus.cdb_valid_i) begin
        if (!r_s1[i].rdy && r_s1[i].tag == bus.cdb_rob_tag_i) begin
          r_s1[i].rdy <= 1'b1;
          r_s1[i].val <= bus.cdb_data_i;
        end
        if (!r_s2[i].rdy && r_s2[i].tag == bus.cdb_rob_tag_i) begin
          r_s2[i].rdy <= 1'b1;
          r_s2[i].val <= bus.cdb_data_i;
        end
      end
    end
    if (w_disp) begin
      r_op[w_free]  <= bus.dispatch_opcode_i;
      r_rob[w_free] <= bus.dispatch_rob_tag_i;
      r_s1[w_free]  <= w_d1;
      r_s2[w_free]  <= w_d2;
    end
  end

  a_occ_max: assert property (
    @(posedge clk_i) disable iff (!rst_ni) r_occ <= FULL);

  a_occ_cnt: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    r_occ == CNT_W'($countones(r_valid)));

  a_disp_slot: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !w_disp || w_has_free);

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Unified reservation station that sits between rename/dispatch and multiple_execution_units; it is the initiator side of the issue handshake into the execution units.
- Buffers dispatched instructions and holds unresolved operands as ROB tags.
- Snoops the result bus (CDB) to wake up and capture operands.
- Issues one fully-ready instruction per cycle, together with its operand values and ROB tag.

Parameters:
DATA_WIDTH, 32, operand/result width
ROB_SIZE, 32, ROB depth; tag width TAG_W = $clog2(ROB_SIZE)
NUM_ENTRIES, 8, station depth (power of 2, >=2); CNT_W = $clog2(NUM_ENTRIES+1)

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  discard all entries (mispredict/exception)
dispatch_valid_i  in  1  new instruction offered
dispatch_ready_o  out  1  free entry available
dispatch_opcode_i  in  riscv_instr_t  instruction fields
dispatch_rs1_ready_i  in  1  rs1 value valid
dispatch_rs1_value_i  in  DATA_WIDTH  rs1 value
dispatch_rs1_tag_i  in  TAG_W  producer ROB tag of rs1
dispatch_rs2_ready_i / _value_i / _tag_i  in  1/DATA_WIDTH/TAG_W  same for rs2
dispatch_rob_tag_i  in  TAG_W  ROB tag of instruction
issue_valid_o  out  1  ready instruction presented
issue_ready_i  in  1  execution units accept
issue_opcode_o  out  riscv_instr_t  issued instruction
issue_v_rs1_o / issue_v_rs2_o  out  DATA_WIDTH  operand values
issue_rob_tag_o  out  TAG_W  ROB tag
cdb_valid_i  in  1  result broadcast valid
cdb_rob_tag_i  in  TAG_W  broadcast tag
cdb_data_i  in  DATA_WIDTH  broadcast value
occupancy_o  out  CNT_W  number of valid entries

Behaviour:
- Reset: all entry valid bits 0; occupancy_o=0; dispatch_ready_o=1; issue_valid_o=0; issue_* data outputs = 0 (explicitly driven to 0 when issue_valid_o=0).
- Entry state: valid, opcode, rob_tag, per operand {rdy, tag, value}.
- dispatch_ready_o = (registered occupancy < NUM_ENTRIES).
  - Not influenced by same-cycle issue: an entry freed by issue is reusable from the next cycle.
- Dispatch (valid&&ready, no flush): write lowest-index free entry at clock edge; occupancy +1.
- Dispatch-time CDB bypass: for an operand with rdy_i=0 and cdb_valid_i && cdb_rob_tag_i==tag_i in the same cycle, store rdy=1 and value=cdb_data_i.
- Wakeup: every valid entry operand with rdy=0 and tag==cdb_rob_tag_i while cdb_valid_i sets rdy=1 and captures cdb_data_i at the edge. All matches update in parallel.
- Entry is issuable when valid && rs1.rdy && rs2.rdy, using registered state only. CDB data reaches issue no earlier than the cycle after broadcast (no CDB-to-issue combinational path).
- Select: lowest-index issuable entry (fixed priority).
  - issue_* outputs are combinational from the selected entry.
  - issue_valid_o = any issuable entry.
- Issue handshake: transfer when issue_valid_o && issue_ready_i. The selected entry is cleared at the edge; occupancy -1.
  - issue_ready_i may depend combinationally on issue_opcode_o. It must not depend on issue_valid_o.
  - Presented instruction may change while not accepted (no hold requirement).
  - Head-of-line blocking on a busy unit type is accepted.
- Simultaneous dispatch and issue: occupancy unchanged; the dispatch never targets the entry being issued in that cycle.
- Full (occupancy==NUM_ENTRIES): dispatch_ready_o=0; issue still permitted.
- Empty: issue_valid_o=0.
- flush_i:
  - All valid bits cleared at the edge; occupancy -> 0.
  - A same-cycle dispatch is dropped.
  - issue_valid_o is forced 0 combinationally while flush_i=1.
- Reset mid-operation: asynchronous clear of all valid bits and occupancy; payload registers need no reset.
- occupancy_o is registered and never exceeds NUM_ENTRIES. The count update is saturating-safe and assertion-checked.

Test Plan:
- Reset, dispatch ADD with rs1=5 and rs2=7 both ready, issue_ready_i=1 -> issue_valid_o=1 the cycle after dispatch; v_rs1=5, v_rs2=7, rob_tag matches; occupancy 1->0.
- Dispatch with rs2 pending tag 3, then cdb_valid_i with tag=3 and data=0xDEAD two cycles later -> issue_valid_o rises the cycle after the broadcast with v_rs2=0xDEAD. A CDB tag=4 broadcast does not wake the entry.
- Dispatch with rs1 pending tag 9 while the CDB broadcasts tag 9, data 0x11 in the same cycle -> entry stored ready; issues next cycle with v_rs1=0x11.
- issue_ready_i=0, dispatch 8 ready instructions -> dispatch_ready_o=0 and occupancy=8, 9th dispatch refused. Then issue_ready_i=1 -> entries issue in index order 0..7, one per cycle.
- Full station, same-cycle issue accept + dispatch offer -> dispatch refused; next cycle dispatch_ready_o=1 and the new instruction lands in the freed entry.
- Flush with 5 entries (some pending) and a simultaneous dispatch -> occupancy=0 next cycle, issue_valid_o=0, and a later CDB broadcast of a pending tag produces no issue.
